// File: rtl/i2c_pkg.sv
// i2c_pkg
//   Shared definitions for the I2C register-access sequencer:
//   - state_t     : sequencer state encoding (also driven on the debug port)
//   - I2C_WR/RD   : R/W bit appended to the 7-bit device address
//   - TIMEOUT_DEFAULT : default per-transaction cycle budget
//   - SENDS_WR/RD : number of m_sended strobes a complete transfer produces
//   - NACK_GUARD  : cycles after LAUNCH before m_ready=1 counts as an early stop
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LAUNCH  = 4'd1,
    ADDR_W  = 4'd2,
    REG     = 4'd3,
    WDATA   = 4'd4,
    RESTART = 4'd5,
    ADDR_R  = 4'd6,
    RDATA   = 4'd7,
    DRAIN   = 4'd8,
    DONE    = 4'd9
  } state_t;

  localparam logic        I2C_WR          = 1'b0;
  localparam logic        I2C_RD          = 1'b1;
  localparam logic [19:0] TIMEOUT_DEFAULT = 20'd1000000;
  localparam logic [1:0]  SENDS_WR        = 2'd3;  // addrW, reg, wdata
  localparam logic [1:0]  SENDS_RD        = 2'd3;  // addrW, reg, addrR
  localparam logic [19:0] NACK_GUARD      = 20'd2;

endpackage

// File: rtl/i2c_rr_arb.sv
// i2c_rr_arb
//   Two-way round-robin arbiter. When both requesters are active the one
//   that was served last loses; a single active requester always wins.
//   The last-served register resets to 1 so requester 0 wins the first tie.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   req[1:0]   : request vector
//   take       : grant is being accepted this cycle (updates last-served)
//   gnt        : index of the winning requester (combinational)
module i2c_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt
);

  logic last;

  always_comb begin
    gnt = req[1];
    if (req == 2'b11) gnt = ~last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (take) begin
      last <= gnt;
    end
  end

endmodule

// File: rtl/i2c_reg_access.sv
// i2c_reg_access
//   Arbitrates two register-access requesters onto one byte-level I2C master
//   and sequences a single-byte register write or read:
//     write: S {dev,0} reg wdata P
//     read : S {dev,0} reg Sr {dev,1} rdata P
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   req/rw/dev/regaddr/wdata : per-requester request fields, {req1,req0}
//   done, err, rdata      : completion pulse (per requester), error flag, read byte
//   m_start/m_send/m_receive/m_datasend : control towards the I2C master
//   m_ready/m_sended/m_received/m_datareceive : status from the I2C master
//   dbg_state             : current sequencer state
// Handshake: a requester raises req[i] with its fields stable and holds it
//   until done[i] pulses for one cycle; err and rdata are valid in that
//   cycle. Dropping req early does not cancel a granted transaction.
module i2c_reg_access
  import i2c_pkg::*;
#(
  parameter logic [19:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  rw,
  input  logic [13:0] dev,
  input  logic [15:0] regaddr,
  input  logic [15:0] wdata,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        m_start,
  output logic        m_send,
  output logic        m_receive,
  output logic [7:0]  m_datasend,
  input  logic        m_ready,
  input  logic        m_sended,
  input  logic        m_received,
  input  logic [7:0]  m_datareceive,
  output logic [3:0]  dbg_state
);

  state_t      state;
  logic        arb_gnt;
  logic        arb_take;
  logic        gnt_q;
  logic        rw_q;
  logic        err_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wd_q;
  logic [19:0] tcnt;
  logic [1:0]  scnt;
  logic        rcnt;

  logic [6:0]  dev_sel;
  logic [1:0]  scnt_nx;
  logic        rcnt_nx;
  logic        active;
  logic        complete;
  logic        tmo;
  logic        nack;

  i2c_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .take  (arb_take),
    .gnt   (arb_gnt)
  );

  assign arb_take  = (state == IDLE) && m_ready && (req != 2'b00);
  assign dev_sel   = arb_gnt ? dev[13:7] : dev[6:0];
  assign active    = state inside {LAUNCH, ADDR_W, REG, WDATA, RESTART, ADDR_R, RDATA};
  assign dbg_state = state;

  // Strobe counts including this cycle's strobe, so a strobe arriving
  // together with m_ready is credited before completion is judged.
  assign scnt_nx  = (m_sended && (scnt != 2'd3)) ? scnt + 2'd1 : scnt;
  assign rcnt_nx  = rcnt | m_received;
  assign complete = (rw_q == I2C_RD) ? ((scnt_nx == SENDS_RD) && rcnt_nx)
                                     : (scnt_nx == SENDS_WR);

  // The master returning to ready before all strobes arrived means it
  // stopped on a NACK. The guard skips the cycles where m_ready may still
  // show the pre-start idle level.
  assign tmo  = active && (tcnt >= TIMEOUT);
  assign nack = active && m_ready && (tcnt >= NACK_GUARD) && !complete;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      done       <= 2'b00;
      err        <= 1'b0;
      rdata      <= 8'h00;
      m_start    <= 1'b0;
      m_send     <= 1'b0;
      m_receive  <= 1'b0;
      m_datasend <= 8'h00;
      gnt_q      <= 1'b0;
      rw_q       <= 1'b0;
      err_q      <= 1'b0;
      dev_q      <= 7'h00;
      reg_q      <= 8'h00;
      wd_q       <= 8'h00;
      tcnt       <= 20'd0;
      scnt       <= 2'd0;
      rcnt       <= 1'b0;
    end else begin
      m_start <= 1'b0;  // start/restart are single-cycle strobes
      if ((state != IDLE) && (tcnt != '1)) tcnt <= tcnt + 20'd1;
      if (active) begin
        scnt <= scnt_nx;
        rcnt <= rcnt_nx;
      end

      case (state)
        IDLE: begin
          if (arb_take) begin
            gnt_q      <= arb_gnt;
            rw_q       <= rw[arb_gnt];
            dev_q      <= dev_sel;
            reg_q      <= arb_gnt ? regaddr[15:8] : regaddr[7:0];
            wd_q       <= arb_gnt ? wdata[15:8] : wdata[7:0];
            err_q      <= 1'b0;
            tcnt       <= 20'd0;
            scnt       <= 2'd0;
            rcnt       <= 1'b0;
            m_datasend <= {dev_sel, I2C_WR};
            m_start    <= 1'b1;
            state      <= LAUNCH;
          end
        end

        DRAIN: begin
          if (m_ready) begin
            done[gnt_q] <= 1'b1;
            err         <= err_q;
            state       <= DONE;
          end
        end

        DONE: begin
          done  <= 2'b00;
          err   <= 1'b0;
          state <= IDLE;
        end

        default: begin
          if (tmo) begin
            // Abort, but let the master finish its stop before reporting.
            m_send    <= 1'b0;
            m_receive <= 1'b0;
            err_q     <= 1'b1;
            state     <= DRAIN;
          end else if (nack) begin
            m_send      <= 1'b0;
            m_receive   <= 1'b0;
            done[gnt_q] <= 1'b1;
            err         <= 1'b1;
            state       <= DONE;
          end else begin
            case (state)
              LAUNCH: state <= ADDR_W;
              ADDR_W: begin
                if (m_sended) begin
                  m_datasend <= reg_q;
                  m_send     <= 1'b1;
                  state      <= REG;
                end
              end
              REG: begin
                if (m_sended) begin
                  if (rw_q == I2C_RD) begin
                    m_send     <= 1'b0;
                    m_datasend <= {dev_q, I2C_RD};
                    m_start    <= 1'b1;  // repeated start, master is still busy
                    state      <= RESTART;
                  end else begin
                    m_datasend <= wd_q;
                    state      <= WDATA;
                  end
                end
              end
              WDATA: begin
                if (m_sended) begin
                  m_send <= 1'b0;
                  state  <= DRAIN;
                end
              end
              RESTART: begin
                if (m_sended) begin
                  m_receive <= 1'b1;
                  state     <= ADDR_R;
                end
              end
              ADDR_R: state <= RDATA;
              RDATA: begin
                if (m_received) begin
                  rdata     <= m_datareceive;
                  m_receive <= 1'b0;  // single byte: master NACKs and stops
                  state     <= DRAIN;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_access.sv
// tb_i2c_reg_access
//   Directed bench for i2c_reg_access with a behavioural byte-level I2C
//   master/slave model. Bytes the model sees on the bus are recorded and
//   compared against hand-computed expectations.
module tb_i2c_reg_access;
  import i2c_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  rw;
  logic [13:0] dev;
  logic [15:0] regaddr;
  logic [15:0] wdata;
  logic [1:0]  done;
  logic        err;
  logic [7:0]  rdata;
  logic        m_start;
  logic        m_send;
  logic        m_receive;
  logic [7:0]  m_datasend;
  logic        m_ready;
  logic        m_sended;
  logic        m_received;
  logic [7:0]  m_datareceive;
  logic [3:0]  dbg_state;

  int         n_checks;
  int         n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] bus_q[$];
  int         start_cnt = 0;
  logic       hang;
  int         nack_idx;
  logic [7:0] rd_byte;

  i2c_reg_access #(.TIMEOUT(20'd200)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .rw            (rw),
    .dev           (dev),
    .regaddr       (regaddr),
    .wdata         (wdata),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .m_start       (m_start),
    .m_send        (m_send),
    .m_receive     (m_receive),
    .m_datasend    (m_datasend),
    .m_ready       (m_ready),
    .m_sended      (m_sended),
    .m_received    (m_received),
    .m_datareceive (m_datareceive),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- master/slave model ----------------
  // Each byte takes 3 cycles. Right after an m_sended pulse the model looks
  // at the sequencer's reply: m_start = (re)start with m_datasend, m_send =
  // next byte, m_receive = read one byte, otherwise stop.
  typedef enum logic [2:0] {M_IDLE, M_XFER, M_HANG, M_DECIDE, M_RECV, M_STOP} mst_t;
  mst_t ms;
  int   dly;
  int   byte_idx;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_ready       = 1'b1;
      m_sended      = 1'b0;
      m_received    = 1'b0;
      m_datareceive = 8'h00;
      ms            = M_IDLE;
      dly           = 0;
      byte_idx      = 0;
    end else begin
      m_sended   = 1'b0;
      m_received = 1'b0;
      case (ms)
        M_IDLE: begin
          if (m_start) begin
            bus_q.push_back(m_datasend);
            start_cnt++;
            m_ready  = 1'b0;
            byte_idx = 0;
            dly      = 3;
            ms       = M_XFER;
          end
        end
        M_XFER: begin
          if (hang) ms = M_HANG;
          else if (dly > 1) dly = dly - 1;
          else if (byte_idx == nack_idx) begin
            m_ready = 1'b1;
            ms      = M_IDLE;
          end else begin
            m_sended = 1'b1;
            byte_idx++;
            ms = M_DECIDE;
          end
        end
        M_HANG: begin
          if (!hang) begin
            m_ready = 1'b1;
            ms      = M_IDLE;
          end
        end
        M_DECIDE: begin
          if (m_start) begin
            bus_q.push_back(m_datasend);
            start_cnt++;
            dly = 3;
            ms  = M_XFER;
          end else if (m_send) begin
            bus_q.push_back(m_datasend);
            dly = 3;
            ms  = M_XFER;
          end else if (m_receive) begin
            dly = 3;
            ms  = M_RECV;
          end else begin
            dly = 2;
            ms  = M_STOP;
          end
        end
        M_RECV: begin
          if (dly > 1) dly = dly - 1;
          else begin
            m_datareceive = rd_byte;
            m_received    = 1'b1;
            dly           = 2;
            ms            = M_STOP;
          end
        end
        default: begin
          if (dly > 1) dly = dly - 1;
          else begin
            m_ready = 1'b1;
            ms      = M_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- check / scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_bus(input string tag, input int base);
    check({tag, "_nbytes"}, 32'(bus_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < bus_q.size())
        check({tag, "_byte"}, 32'(bus_q[base + i]), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int r, input logic rwv, input logic [6:0] d,
                         input logic [7:0] ra, input logic [7:0] wd);
    rw[r] = rwv;
    if (r == 0) begin
      dev[6:0]     = d;
      regaddr[7:0] = ra;
      wdata[7:0]   = wd;
    end else begin
      dev[13:7]     = d;
      regaddr[15:8] = ra;
      wdata[15:8]   = wd;
    end
    req[r] = 1'b1;
  endtask

  task automatic wait_done(input string tag, output logic [1:0] d, output logic e,
                           output logic s);
    bit got;
    got = 1'b0;
    d = 2'b00;
    e = 1'b0;
    s = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        got = 1'b1;
        d   = done;
        e   = err;
        s   = m_send;
      end
    end
    if (!got) check({tag, "_done_timeout"}, 32'(got), 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] d;
    logic       e;
    logic       s;
    int         base;
    int         sc;
    bit         got;
    bit         seen;

    n_checks = 0;
    n_fail   = 0;
    hang     = 1'b0;
    nack_idx = 99;
    rd_byte  = 8'h00;
    req      = 2'b00;
    rw       = 2'b00;
    dev      = '0;
    regaddr  = '0;
    wdata    = '0;
    reset    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outs", 32'({done, err, rdata, m_start, m_send, m_receive, m_datasend}), 0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;
    @(negedge clk);

    // Write, requester 0: A0 10 A5
    base = bus_q.size();
    sc   = start_cnt;
    set_req(0, 1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done("wr", d, e, s);
    req[0] = 1'b0;
    check("wr_done", 32'(d), 1);
    check("wr_err", 32'(e), 0);
    check("wr_starts", 32'(start_cnt - sc), 1);
    exp_q = {8'hA0, 8'h10, 8'hA5};
    check_bus("wr", base);

    // NACK on address, requester 0
    repeat (2) @(negedge clk);
    base     = bus_q.size();
    nack_idx = 0;
    set_req(0, 1'b0, 7'h22, 8'h00, 8'h00);
    wait_done("nack", d, e, s);
    req[0]   = 1'b0;
    nack_idx = 99;
    check("nack_done", 32'(d), 1);
    check("nack_err", 32'(e), 1);
    check("nack_send", 32'(s), 0);
    exp_q = {8'h44};
    check_bus("nack", base);

    // Read, requester 1: D0 75 Sr D1, data 71
    repeat (2) @(negedge clk);
    base    = bus_q.size();
    sc      = start_cnt;
    rd_byte = 8'h71;
    set_req(1, 1'b1, 7'h68, 8'h75, 8'h00);
    wait_done("rd", d, e, s);
    req[1] = 1'b0;
    check("rd_done", 32'(d), 2);
    check("rd_err", 32'(e), 0);
    check("rd_rdata", 32'(rdata), 32'h71);
    check("rd_starts", 32'(start_cnt - sc), 2);
    exp_q = {8'hD0, 8'h75, 8'hD1};
    check_bus("rd", base);

    // Contention: both held, last served was 1 -> 0,1,0
    repeat (2) @(negedge clk);
    base = bus_q.size();
    set_req(0, 1'b0, 7'h50, 8'h01, 8'h11);
    set_req(1, 1'b0, 7'h51, 8'h02, 8'h22);
    wait_done("cont1", d, e, s);
    check("cont1_done", 32'(d), 1);
    wait_done("cont2", d, e, s);
    check("cont2_done", 32'(d), 2);
    wait_done("cont3", d, e, s);
    req = 2'b00;
    check("cont3_done", 32'(d), 1);
    exp_q = {8'hA0, 8'h01, 8'h11, 8'hA2, 8'h02, 8'h22, 8'hA0, 8'h01, 8'h11};
    check_bus("cont", base);
    check("rdata_hold", 32'(rdata), 32'h71);

    // Timeout: bus stuck after the address byte
    repeat (2) @(negedge clk);
    base = bus_q.size();
    hang = 1'b1;
    set_req(0, 1'b0, 7'h30, 8'h01, 8'h02);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (m_start) got = 1'b1;
    end
    check("tmo_launch", 32'(got), 1);
    repeat (200) @(negedge clk);
    check("tmo_before", 32'(dbg_state), 32'(ADDR_W));
    @(negedge clk);
    check("tmo_drain", 32'(dbg_state), 32'(DRAIN));
    check("tmo_strobes", 32'({m_start, m_send, m_receive}), 0);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done != 2'b00) seen = 1'b1;
    end
    check("tmo_no_early_done", 32'(seen), 0);
    hang = 1'b0;
    wait_done("tmo", d, e, s);
    req[0] = 1'b0;
    check("tmo_done", 32'(d), 1);
    check("tmo_err", 32'(e), 1);
    exp_q = {8'h60};
    check_bus("tmo", base);

    // Reset while receiving the read byte
    repeat (2) @(negedge clk);
    rd_byte = 8'h3C;
    set_req(1, 1'b1, 7'h68, 8'h75, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (dbg_state == 4'(RDATA)) got = 1'b1;
    end
    check("rst_reach_rdata", 32'(got), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_outs", 32'({done, err, rdata, m_start, m_send, m_receive, m_datasend}), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    req  = 2'b00;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done != 2'b00) seen = 1'b1;
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done != 2'b00) seen = 1'b1;
    end
    check("rst_no_done", 32'(seen), 0);

    // Served normally after reset
    base = bus_q.size();
    set_req(0, 1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done("post", d, e, s);
    req[0] = 1'b0;
    check("post_done", 32'(d), 1);
    check("post_err", 32'(e), 0);
    check("post_rdata", 32'(rdata), 0);
    exp_q = {8'hA0, 8'h10, 8'hA5};
    check_bus("post", base);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
